// File: rtl/tmr_resp_gate.sv
// tmr_resp_gate: return-path companion to the TMR request voter.
// Gates voted OBI requests onto the bus and copies every bus response to all harts.
// It counts outstanding transactions per bus and runs the recovery sequence after a
// voter mismatch (RUN -> DRAIN -> RESYNC -> RUN).
// Optional feature macro: TMR_RESP_TIMEOUT_EN adds a DRAIN+RESYNC watchdog and a sticky FATAL state.

package tmr_resp_gate_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

module tmr_resp_gate
    import tmr_resp_gate_pkg::*;
#(
    parameter int NHARTS          = 3,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TIMEOUT         = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  obi_req_t          voted_instr_req_i,
    input  obi_req_t          voted_data_req_i,
    output obi_req_t          bus_instr_req_o,
    output obi_req_t          bus_data_req_o,
    input  obi_resp_t         bus_instr_resp_i,
    input  obi_resp_t         bus_data_resp_i,
    output obi_resp_t         core_instr_resp_o [NHARTS],
    output obi_resp_t         core_data_resp_o  [NHARTS],
    input  logic              enable_i,
    input  logic              error_i,
    input  logic [NHARTS-1:0] error_id_i,
    output logic [NHARTS-1:0] fault_id_o,
    output logic              resync_req_o,
    input  logic              resync_ack_i,
    output logic              busy_o,
    output logic              protocol_err_o,
    output logic              fatal_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
`ifdef TMR_RESP_TIMEOUT_EN
        RESYNC = 2'd2,
        FATAL  = 2'd3
`else
        RESYNC = 2'd2
`endif
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] instr_cnt, data_cnt;
    logic [CW-1:0] instr_cnt_next, data_cnt_next;
    logic          instr_gate, data_gate;
    logic          instr_inc, data_inc;
    logic          new_error;
    logic          timeout_hit;

    assign new_error = error_i & enable_i;

    // Saturating outstanding counter step: simultaneous grant and response cancel out,
    // and a stray response at zero leaves the counter at zero.
    function automatic logic [CW-1:0] cnt_step(input logic [CW-1:0] cnt,
                                               input logic inc, input logic dec);
        logic [CW-1:0] res;
        res = cnt;
        if (inc && !dec)
            res = cnt + 1'b1;
        else if (dec && !inc && (cnt != '0))
            res = cnt - 1'b1;
        return res;
    endfunction

    // Request gate is only open in RUN and while the bus has room for another transaction.
    always_comb begin
        instr_gate = (state == RUN) && (instr_cnt < MAX_CNT);
        data_gate  = (state == RUN) && (data_cnt < MAX_CNT);
    end

    // Requests pass through untouched except for the gated req bit.
    always_comb begin
        bus_instr_req_o     = voted_instr_req_i;
        bus_instr_req_o.req = voted_instr_req_i.req & instr_gate;
        bus_data_req_o      = voted_data_req_i;
        bus_data_req_o.req  = voted_data_req_i.req & data_gate;
    end

    // Every hart sees the same bus response; only gnt is masked when the gate is closed.
    always_comb begin
        for (int i = 0; i < NHARTS; i++) begin
            core_instr_resp_o[i]     = bus_instr_resp_i;
            core_instr_resp_o[i].gnt = bus_instr_resp_i.gnt & instr_gate;
            core_data_resp_o[i]      = bus_data_resp_i;
            core_data_resp_o[i].gnt  = bus_data_resp_i.gnt & data_gate;
        end
    end

    // Next values of the outstanding counters, also used to decide when DRAIN is done.
    always_comb begin
        instr_inc      = bus_instr_req_o.req & bus_instr_resp_i.gnt;
        data_inc       = bus_data_req_o.req & bus_data_resp_i.gnt;
        instr_cnt_next = cnt_step(instr_cnt, instr_inc, bus_instr_resp_i.rvalid);
        data_cnt_next  = cnt_step(data_cnt, data_inc, bus_data_resp_i.rvalid);
    end

    // Outstanding counters and the registered protocol-error pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_cnt      <= '0;
            data_cnt       <= '0;
            protocol_err_o <= 1'b0;
        end else begin
            instr_cnt      <= instr_cnt_next;
            data_cnt       <= data_cnt_next;
            protocol_err_o <= (bus_instr_resp_i.rvalid && (instr_cnt == '0)) ||
                              (bus_data_resp_i.rvalid && (data_cnt == '0));
        end
    end

`ifdef TMR_RESP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer;

    // Watchdog: held at zero in RUN so it starts from zero on DRAIN entry, then counts
    // every DRAIN and RESYNC cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            timer <= '0;
        else if (state == RUN)
            timer <= '0;
        else if ((state == DRAIN) || (state == RESYNC))
            timer <= timer + 1'b1;
    end

    assign timeout_hit = (timer == TW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
`endif

    // Recovery state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= RUN;
        else
            state <= state_next;
    end

    // Recovery next-state logic; the watchdog overrides everything while recovering.
    always_comb begin
        state_next = state;
        case (state)
            RUN:    if (new_error) state_next = DRAIN;
            DRAIN:  if ((instr_cnt_next == '0) && (data_cnt_next == '0)) state_next = RESYNC;
            RESYNC: if (resync_ack_i) state_next = RUN;
`ifdef TMR_RESP_TIMEOUT_EN
            FATAL:  state_next = FATAL;
`endif
            default: state_next = RUN;
        endcase
`ifdef TMR_RESP_TIMEOUT_EN
        if (((state == DRAIN) || (state == RESYNC)) && timeout_hit)
            state_next = FATAL;
`else
        if (timeout_hit)
            state_next = RUN;
`endif
    end

    // Status outputs decoded from the registered state and counters.
    always_comb begin
        resync_req_o = (state == RESYNC);
        busy_o       = (instr_cnt != '0) || (data_cnt != '0);
`ifdef TMR_RESP_TIMEOUT_EN
        fatal_o      = (state == FATAL);
`else
        fatal_o      = 1'b0;
`endif
    end

    // Faulty-hart record: captured on the first mismatch, accumulated while draining,
    // cleared once the safety controller acknowledges the resync.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            fault_id_o <= '0;
        else if ((state == RUN) && new_error)
            fault_id_o <= error_id_i;
        else if ((state == DRAIN) && new_error)
            fault_id_o <= fault_id_o | error_id_i;
        else if ((state == RESYNC) && (state_next == RUN))
            fault_id_o <= '0;
    end

endmodule
